// File: rtl/fft_addr_gen.sv
// Radix-2 FFT address sequencer: butterfly operand addresses, twiddle ROM
// index and ping-pong bank select for runtime-selectable sizes up to 2^LOG2N.
module fft_addr_gen #(
  parameter int LOG2N        = 10,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [3:0]       log2n_i,
  input  logic             inv_i,
  input  logic             stall_i,
  input  logic             abort_i,
  output logic [LOG2N-1:0] address_a_o,
  output logic [LOG2N-1:0] address_b_o,
  output logic [LOG2N-2:0] twiddle_addr_o,
  output logic             memsel_o,
  output logic             conj_o,
  output logic [3:0]       stage_o,
  output logic             valid_o,
  output logic             last_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int JW = LOG2N - 1;

  typedef enum logic [1:0] {IDLE, GEN, FLUSH, DONE} state_t;

  state_t           state_reg;
  logic [3:0]       m_reg;
  logic [3:0]       s_reg;
  logic [JW-1:0]    j_reg;
  logic [3:0]       cnt_reg;

  logic [3:0]       m_sel;
  logic [JW-1:0]    j_last;
  logic [LOG2N-1:0] m_mask;
  logic [LOG2N-1:0] x_a, x_b;
  logic [LOG2N-1:0] addr_a_c, addr_b_c;
  logic [JW-1:0]    tw_c;

  // Out-of-range size requests fall back to the full transform.
  assign m_sel = (log2n_i >= 4'd2 && log2n_i <= 4'(LOG2N)) ? log2n_i : 4'(LOG2N);

  always_comb begin
    j_last   = (JW'(1) << (m_reg - 4'd1)) - JW'(1);
    m_mask   = (LOG2N'(1) << m_reg) - LOG2N'(1);
    x_a      = {j_reg, 1'b0};
    x_b      = {j_reg, 1'b1};
    // Rotate within the active M bits: low part plus the bits wrapped from the top.
    addr_a_c = ((x_a << s_reg) | (x_a >> (m_reg - s_reg))) & m_mask;
    addr_b_c = ((x_b << s_reg) | (x_b >> (m_reg - s_reg))) & m_mask;
    // Twiddle index is scaled so a full-size ROM serves every smaller transform.
    tw_c     = ((j_reg << (m_reg - 4'd1 - s_reg)) & j_last) << (4'(LOG2N) - m_reg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      m_reg          <= 4'd0;
      s_reg          <= 4'd0;
      j_reg          <= '0;
      cnt_reg        <= 4'd0;
      address_a_o    <= '0;
      address_b_o    <= '0;
      twiddle_addr_o <= '0;
      memsel_o       <= 1'b0;
      conj_o         <= 1'b0;
      stage_o        <= 4'd0;
      valid_o        <= 1'b0;
      last_o         <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      last_o  <= 1'b0;
      done_o  <= 1'b0;
      if (abort_i) begin
        state_reg      <= IDLE;
        s_reg          <= 4'd0;
        j_reg          <= '0;
        cnt_reg        <= 4'd0;
        address_a_o    <= '0;
        address_b_o    <= '0;
        twiddle_addr_o <= '0;
        busy_o         <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start_i) begin
              state_reg <= GEN;
              m_reg     <= m_sel;
              conj_o    <= inv_i;
              s_reg     <= 4'd0;
              j_reg     <= '0;
              cnt_reg   <= 4'd0;
              stage_o   <= 4'd0;
              memsel_o  <= 1'b0;
              busy_o    <= 1'b1;
            end
          end
          GEN: begin
            // A stalled cycle only drops valid; the last addresses stay on the bus.
            if (!stall_i) begin
              address_a_o    <= addr_a_c;
              address_b_o    <= addr_b_c;
              twiddle_addr_o <= tw_c;
              stage_o        <= s_reg;
              memsel_o       <= s_reg[0];
              valid_o        <= 1'b1;
              last_o         <= (j_reg == j_last);
              if (j_reg == j_last) begin
                state_reg <= FLUSH;
                j_reg     <= '0;
                cnt_reg   <= 4'd0;
              end else begin
                j_reg <= j_reg + JW'(1);
              end
            end
          end
          FLUSH: begin
            if (!stall_i) begin
              address_a_o    <= '0;
              address_b_o    <= '0;
              twiddle_addr_o <= '0;
              if (cnt_reg == 4'(FLUSH_CYCLES - 1)) begin
                cnt_reg <= 4'd0;
                if (s_reg == m_reg - 4'd1) begin
                  state_reg <= DONE;
                  done_o    <= 1'b1;
                end else begin
                  state_reg <= GEN;
                  s_reg     <= s_reg + 4'd1;
                end
              end else begin
                cnt_reg <= cnt_reg + 4'd1;
              end
            end
          end
          DONE: begin
            state_reg <= IDLE;
            s_reg     <= 4'd0;
            busy_o    <= 1'b0;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fft_addr_gen.sv
// Bench for fft_addr_gen (LOG2N=4): table vectors, hand-made stall/abort/reset
// sequences and randomized runs checked against a stage/butterfly position model.
module tb_fft_addr_gen;

  localparam int LOG2N = 4;
  localparam int FLUSH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start_i = 1'b0;
  logic [3:0]       log2n_i = 4'd0;
  logic             inv_i = 1'b0;
  logic             stall_i = 1'b0;
  logic             abort_i = 1'b0;
  logic [LOG2N-1:0] address_a_o, address_b_o;
  logic [LOG2N-2:0] twiddle_addr_o;
  logic             memsel_o, conj_o, valid_o, last_o, busy_o, done_o;
  logic [3:0]       stage_o;

  int n_cmp = 0;
  int n_bad = 0;
  int obs_a [0:3][0:7];
  int obs_b [0:3][0:7];
  int obs_t [0:3][0:7];
  int obs_m [0:3][0:7];

  typedef struct {
    int lg; int s; int j; int a; int b; int tw; int ms;
  } vec_t;
  vec_t tbl [7];

  fft_addr_gen #(.LOG2N(LOG2N), .FLUSH_CYCLES(FLUSH)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .log2n_i(log2n_i),
    .inv_i(inv_i), .stall_i(stall_i), .abort_i(abort_i),
    .address_a_o(address_a_o), .address_b_o(address_b_o),
    .twiddle_addr_o(twiddle_addr_o), .memsel_o(memsel_o), .conj_o(conj_o),
    .stage_o(stage_o), .valid_o(valid_o), .last_o(last_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ref_rot(input int x, input int s, input int m);
    return ((x << s) | (x >> (m - s))) & ((1 << m) - 1);
  endfunction

  function automatic int ref_tw(input int j, input int s, input int m);
    return ((j << (m - 1 - s)) % (1 << (m - 1))) << (LOG2N - m);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a"}, address_a_o, 0);
    chk({tag, "_b"}, address_b_o, 0);
    chk({tag, "_tw"}, twiddle_addr_o, 0);
    chk({tag, "_valid"}, valid_o, 0);
    chk({tag, "_last"}, last_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_stage"}, stage_o, 0);
    chk({tag, "_memsel"}, memsel_o, 0);
    chk({tag, "_conj"}, conj_o, 0);
  endtask

  // One transform. p counts un-stalled GEN/FLUSH cycles; stage and butterfly
  // index follow from p by plain division.
  task automatic run(input int lg, input bit inv, input int stall_pct,
                     input int stall_at, input int abort_at, input int rst_at);
    int m, h, per, w, p, s, k, stalls, busy_cnt, done_cnt, valid_cnt, cyc;
    bit stl, fin;
    m   = (lg >= 2 && lg <= LOG2N) ? lg : LOG2N;
    h   = 1 << (m - 1);
    per = h + FLUSH;
    w   = m * per;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 8; b++) begin
        obs_a[a][b] = -1; obs_b[a][b] = -1; obs_t[a][b] = -1; obs_m[a][b] = -1;
      end
    start_i = 1'b1; log2n_i = 4'(lg); inv_i = inv;
    @(posedge clk); #1;
    start_i = 1'b0; log2n_i = 4'($urandom_range(15)); inv_i = ~inv;
    chk("start_busy", busy_o, 1);
    chk("start_valid", valid_o, 0);
    p = 0; stalls = 0; busy_cnt = busy_o; done_cnt = 0; valid_cnt = 0; cyc = 0; fin = 1'b0;
    while (!fin) begin
      if (p == abort_at) begin
        abort_i = 1'b1; stall_i = 1'b1; start_i = 1'b1;
        @(posedge clk); #1;
        abort_i = 1'b0; stall_i = 1'b0; start_i = 1'b0;
        chk("abort_valid", valid_o, 0);
        chk("abort_busy", busy_o, 0);
        chk("abort_done", done_o, 0);
        $display("run lg=%0d aborted at p=%0d", lg, p);
        return;
      end
      if (p == rst_at) begin
        stall_i = 1'b0; start_i = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rst_mid");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_rel_busy", busy_o, 0);
        chk("rst_rel_valid", valid_o, 0);
        $display("run lg=%0d reset at p=%0d", lg, p);
        return;
      end
      if (stall_at >= 0 && p == stall_at && stalls < 5) stl = 1'b1;
      else stl = ($urandom_range(99) < stall_pct);
      stall_i = stl;
      start_i = ($urandom_range(3) == 0);
      log2n_i = 4'($urandom_range(15));
      @(posedge clk); #1;
      cyc++;
      busy_cnt += busy_o;
      done_cnt += done_o;
      if (p < w) begin
        if (stl) begin
          stalls++;
          chk("stall_valid", valid_o, 0);
          chk("stall_last", last_o, 0);
        end else begin
          s = p / per;
          k = p % per;
          if (k < h) begin
            chk("valid", valid_o, 1);
            chk("addr_a", address_a_o, ref_rot(2 * k, s, m));
            chk("addr_b", address_b_o, ref_rot(2 * k + 1, s, m));
            chk("twiddle", twiddle_addr_o, ref_tw(k, s, m));
            chk("stage", stage_o, s);
            chk("memsel", memsel_o, s % 2);
            chk("last", last_o, (k == h - 1) ? 1 : 0);
            obs_a[s][k] = address_a_o; obs_b[s][k] = address_b_o;
            obs_t[s][k] = twiddle_addr_o; obs_m[s][k] = memsel_o;
            valid_cnt++;
          end else begin
            chk("flush_valid", valid_o, 0);
            chk("flush_last", last_o, 0);
            chk("flush_a", address_a_o, 0);
            chk("flush_b", address_b_o, 0);
            chk("flush_tw", twiddle_addr_o, 0);
          end
          p++;
        end
        chk("busy", busy_o, 1);
        chk("done", done_o, (p == w) ? 1 : 0);
        chk("conj", conj_o, inv);
      end else begin
        chk("end_busy", busy_o, 0);
        chk("end_done", done_o, 0);
        chk("end_valid", valid_o, 0);
        fin = 1'b1;
      end
      if (!fin && cyc > w + 400) begin
        n_cmp++; n_bad++;
        $display("FAIL timeout: got no completion after %0d cycles, expected %0d", cyc, w + 1);
        fin = 1'b1;
      end
    end
    start_i = 1'b0; stall_i = 1'b0;
    chk("busy_cycles", busy_cnt, w + 1 + stalls);
    chk("done_pulses", done_cnt, 1);
    chk("valid_count", valid_cnt, m * h);
    $display("run lg=%0d M=%0d inv=%0d stalls=%0d busy=%0d", lg, m, inv, stalls, busy_cnt);
  endtask

  initial begin
    tbl[0] = '{4, 0, 3, 6, 7, 0, 0};
    tbl[1] = '{4, 1, 3, 12, 14, 4, 1};
    tbl[2] = '{4, 3, 5, 5, 13, 5, 1};
    tbl[3] = '{3, 0, 1, 2, 3, 0, 0};
    tbl[4] = '{3, 2, 1, 1, 5, 2, 0};
    tbl[5] = '{15, 3, 5, 5, 13, 5, 1};
    tbl[6] = '{0, 3, 7, 7, 15, 7, 1};

    #2 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    start_i = 1'b1;
    @(posedge clk); #1;
    chk("reset_hold_busy", busy_o, 0);
    start_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", busy_o, 0);

    for (int i = 0; i < 7; i++) begin
      run(tbl[i].lg, 1'b0, 0, -1, -1, -1);
      chk("tbl_a", obs_a[tbl[i].s][tbl[i].j], tbl[i].a);
      chk("tbl_b", obs_b[tbl[i].s][tbl[i].j], tbl[i].b);
      chk("tbl_tw", obs_t[tbl[i].s][tbl[i].j], tbl[i].tw);
      chk("tbl_memsel", obs_m[tbl[i].s][tbl[i].j], tbl[i].ms);
      $display("vector %0d lg=%0d s=%0d j=%0d a=%0d b=%0d tw=%0d", i, tbl[i].lg,
               tbl[i].s, tbl[i].j, obs_a[tbl[i].s][tbl[i].j],
               obs_b[tbl[i].s][tbl[i].j], obs_t[tbl[i].s][tbl[i].j]);
    end

    // Five-cycle stall in stage 1 at j=3, inverse transform.
    run(4, 1'b1, 0, (8 + FLUSH) + 3, -1, -1);
    // Abort in stage 2, then an immediate new start.
    run(4, 1'b0, 0, -1, 2 * (8 + FLUSH) + 2, -1);
    run(3, 1'b1, 0, -1, -1, -1);
    // Asynchronous reset mid-GEN with conj set.
    run(4, 1'b1, 0, -1, -1, 4);
    run(2, 1'b0, 0, -1, -1, -1);

    for (int r = 0; r < 20; r++)
      run(int'($urandom_range(15)), 1'($urandom_range(1)), 25, -1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_addr_gen.md
FFT_ADDR_GEN -- requirements
Module: fft_addr_gen

Interface
REQ-001 SHALL have parameter LOG2N, default 10, meaning maximum FFT size log2 (N = 2^LOG2N); legal range 2..12.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 4, meaning idle cycles inserted after each stage for butterfly pipeline drain; legal range 1..15.
REQ-003 SHALL use one clock; reset is asynchronous and active-low; ports clk, rst_n.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start_i  in  1  begin transform; sampled only in IDLE.
REQ-007 log2n_i  in  4  active size M, sampled with start_i.
REQ-008 inv_i  in  1  inverse transform request, sampled with start_i.
REQ-009 stall_i  in  1  freeze generation while high.
REQ-010 abort_i  in  1  cancel transform.
REQ-011 address_a_o  out  LOG2N  butterfly upper-input/output address.
REQ-012 address_b_o  out  LOG2N  butterfly lower-input/output address.
REQ-013 twiddle_addr_o  out  LOG2N-1  twiddle ROM address.
REQ-014 memsel_o  out  1  ping-pong bank select (stage parity).
REQ-015 conj_o  out  1  conjugate twiddle (latched inv_i).
REQ-016 stage_o  out  4  current stage index s.
REQ-017 valid_o  out  1  address outputs valid this cycle.
REQ-018 last_o  out  1  last butterfly of current stage.
REQ-019 busy_o  out  1  high in any state except IDLE.
REQ-020 done_o  out  1  one-cycle pulse at normal completion.

Function
REQ-021 SHALL implement states IDLE, GEN, FLUSH, DONE.
REQ-022 IDLE: on start_i=1 latch M, inv; next state GEN, s=0, j=0; start_i ignored in any other state.
REQ-023 M SHALL be log2n_i if 2..LOG2N, else LOG2N.
REQ-024 GEN: one butterfly per cycle, j = 0..2^(M-1)-1; after j=2^(M-1)-1 go FLUSH with counter 0.
REQ-025 FLUSH: hold FLUSH_CYCLES cycles, valid_o=0; then if s<M-1 go GEN with s+1, j=0, else go DONE.
REQ-026 DONE: one cycle, then IDLE; done_o=1 in the cycle following DONE-state entry edge (registered).
REQ-027 address_a = rotate-left by s, within M bits, of {j, 1'b0}; address_b = same of {j, 1'b1}; bits above M zero.
REQ-028 twiddle_addr = ((j << (M-1-s)) mod 2^(M-1)) << (LOG2N-M).
REQ-029 memsel_o = s[0]; conj_o = latched inv for whole transform.
REQ-030 All outputs SHALL be registered: values for (s, j) appear one cycle after state is GEN with that (s, j).
REQ-031 last_o = 1 together with valid_o for j = 2^(M-1)-1 only.
REQ-032 stall_i=1 in GEN or FLUSH: j, s, flush counter, state held; next-cycle valid_o=0, other outputs hold.
REQ-033 abort_i=1 in any state: next state IDLE, next-cycle valid_o=0, done_o never pulses; abort beats start and stall.
REQ-034 Busy duration without stall: M*2^(M-1) + M*FLUSH_CYCLES + 1 cycles.
REQ-035 Outside valid cycles address, twiddle outputs SHALL be 0.

Reset
REQ-036 rst_n=0 SHALL immediately force IDLE, s=0, j=0, counters 0, all outputs 0, regardless of clk.
REQ-037 Reset mid-transform SHALL discard it; first cycle after release is IDLE awaiting start_i.

Verification
REQ-038 LOG2N=4, M=4, start: stage0 j=3 -> a=6, b=7, tw=0, memsel=0; stage1 j=3 -> a=12, b=14, tw=4, memsel=1.
REQ-039 LOG2N=4, M=4: stage3 j=5 -> a=5, b=13, tw=5, memsel=1; last_o with j=7 each stage; done_o once after 48 busy cycles (FLUSH_CYCLES=4).
REQ-040 LOG2N=4, log2n_i=3: stage0 j=1 -> a=2, b=3, tw=0; stage2 j=1 -> a=1, b=5, tw=2; log2n_i=15 -> runs as M=4.
REQ-041 stall_i high 5 cycles mid-stage1 -> valid_o low 5 cycles, sequence resumes at same j, busy extends by 5.
REQ-042 abort_i at stage2 -> IDLE next cycle, valid_o=0, busy_o=0, no done_o; new start accepted next cycle.
REQ-043 rst_n low mid-GEN asynchronously -> outputs 0 before next clk edge; start_i while busy ignored, inv_i=1 -> conj_o=1 whole run.
